// File: rtl/bp_be_mmu_tracker.sv
// In-order memory-op tracker between the backend pipeline and memory.
// Circular buffer with alloc / issue / complete / retire pointers.
module bp_be_mmu_tracker #(
   parameter int els_p         = 4,
   parameter int eaddr_width_p = 64,
   parameter int data_width_p  = 64,
   parameter int fu_op_width_p = 5,
   parameter int exc_width_p   = 8,
   parameter int itag_width_p  = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     cmd_v_i,
   output logic                     cmd_ready_o,
   input  logic [fu_op_width_p-1:0] cmd_op_i,
   input  logic [eaddr_width_p-1:0] cmd_addr_i,
   input  logic [data_width_p-1:0]  cmd_data_i,
   input  logic [itag_width_p-1:0]  cmd_itag_i,
   output logic                     mem_cmd_v_o,
   input  logic                     mem_cmd_ready_i,
   output logic [fu_op_width_p-1:0] mem_cmd_op_o,
   output logic [eaddr_width_p-1:0] mem_cmd_addr_o,
   output logic [data_width_p-1:0]  mem_cmd_data_o,
   input  logic                     mem_resp_v_i,
   input  logic [data_width_p-1:0]  mem_resp_data_i,
   input  logic [exc_width_p-1:0]   mem_resp_exc_i,
   output logic                     resp_v_o,
   input  logic                     resp_ready_i,
   output logic [data_width_p-1:0]  resp_data_o,
   output logic [exc_width_p-1:0]   resp_exc_o,
   output logic [itag_width_p-1:0]  resp_itag_o,
   input  logic                     flush_i,
   output logic                     empty_o
);

   localparam int lg_lp = $clog2(els_p);
   localparam logic [lg_lp:0] one_lp = (lg_lp+1)'(1);

   logic [lg_lp:0] r_alloc, r_issue, r_complete, r_retire;
   logic [els_p-1:0] r_done, r_killed;

   logic [fu_op_width_p-1:0] r_op   [els_p];
   logic [eaddr_width_p-1:0] r_addr [els_p];
   logic [data_width_p-1:0]  r_data [els_p];
   logic [itag_width_p-1:0]  r_itag [els_p];
   logic [exc_width_p-1:0]   r_exc  [els_p];

   logic [lg_lp-1:0] w_a_idx, w_i_idx, w_c_idx, w_r_idx;
   logic [lg_lp:0]   w_occ;
   logic w_cmd_fire, w_iss_fire, w_cmpl_fire, w_ret_fire;
   logic w_head_done, w_head_kill;

   assign w_a_idx = r_alloc[lg_lp-1:0];
   assign w_i_idx = r_issue[lg_lp-1:0];
   assign w_c_idx = r_complete[lg_lp-1:0];
   assign w_r_idx = r_retire[lg_lp-1:0];

   // Occupancy never exceeds els_p, so its MSB alone flags "full".
   assign w_occ       = r_alloc - r_retire;
   assign cmd_ready_o = ~w_occ[lg_lp] & ~flush_i;
   assign w_cmd_fire  = cmd_v_i & cmd_ready_o;

   assign mem_cmd_v_o    = (r_issue != r_alloc) & ~flush_i;
   assign w_iss_fire     = mem_cmd_v_o & mem_cmd_ready_i;
   assign mem_cmd_op_o   = r_op[w_i_idx];
   assign mem_cmd_addr_o = r_addr[w_i_idx];
   assign mem_cmd_data_o = r_data[w_i_idx];

   // Responses with nothing outstanding are dropped.
   assign w_cmpl_fire = mem_resp_v_i & (r_complete != r_issue);

   assign w_head_done = (r_retire != r_complete) & r_done[w_r_idx];
   assign w_head_kill = r_killed[w_r_idx];
   assign resp_v_o    = w_head_done & ~w_head_kill & ~flush_i;
   assign w_ret_fire  = (resp_v_o & resp_ready_i)
                      | (w_head_done & w_head_kill);

   assign resp_data_o = r_data[w_r_idx];
   assign resp_exc_o  = r_exc[w_r_idx];
   assign resp_itag_o = r_itag[w_r_idx];
   assign empty_o     = (r_alloc == r_retire);

   // Pointer advance; flush rewinds alloc to drop unissued entries.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_alloc    <= '0;
         r_issue    <= '0;
         r_complete <= '0;
         r_retire   <= '0;
      end else begin
         if (flush_i)
            r_alloc <= r_issue;
         else if (w_cmd_fire)
            r_alloc <= r_alloc + one_lp;
         if (w_iss_fire)
            r_issue <= r_issue + one_lp;
         if (w_cmpl_fire)
            r_complete <= r_complete + one_lp;
         if (w_ret_fire)
            r_retire <= r_retire + one_lp;
      end
   end

   // Done/killed bits; killing free slots is harmless, alloc clears them.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_done   <= '0;
         r_killed <= '0;
      end else begin
         if (w_ret_fire)
            r_done[w_r_idx] <= 1'b0;
         if (w_cmpl_fire)
            r_done[w_c_idx] <= 1'b1;
         if (flush_i)
            r_killed <= '1;
         if (w_cmd_fire) begin
            r_done[w_a_idx]   <= 1'b0;
            r_killed[w_a_idx] <= 1'b0;
         end
      end
   end

   // Entry payloads: command on allocate, response data on complete.
   always_ff @(posedge clk_i) begin
      if (w_cmd_fire) begin
         r_op[w_a_idx]   <= cmd_op_i;
         r_addr[w_a_idx] <= cmd_addr_i;
         r_data[w_a_idx] <= cmd_data_i;
         r_itag[w_a_idx] <= cmd_itag_i;
      end
      if (w_cmpl_fire) begin
         r_data[w_c_idx] <= mem_resp_data_i;
         r_exc[w_c_idx]  <= mem_resp_exc_i;
      end
   end

endmodule

// File: tb/tb_bp_be_mmu_tracker.sv
// Bench for bp_be_mmu_tracker: directed scenarios plus random traffic
// checked against a queue-based model of the tracker.
module tb_bp_be_mmu_tracker;

   localparam int ELS = 4;
   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int OW  = 5;
   localparam int EW  = 8;
   localparam int TW  = 32;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          cmd_v_i, cmd_ready_o;
   logic [OW-1:0] cmd_op_i;
   logic [AW-1:0] cmd_addr_i;
   logic [DW-1:0] cmd_data_i;
   logic [TW-1:0] cmd_itag_i;
   logic          mem_cmd_v_o, mem_cmd_ready_i;
   logic [OW-1:0] mem_cmd_op_o;
   logic [AW-1:0] mem_cmd_addr_o;
   logic [DW-1:0] mem_cmd_data_o;
   logic          mem_resp_v_i;
   logic [DW-1:0] mem_resp_data_i;
   logic [EW-1:0] mem_resp_exc_i;
   logic          resp_v_o, resp_ready_i;
   logic [DW-1:0] resp_data_o;
   logic [EW-1:0] resp_exc_o;
   logic [TW-1:0] resp_itag_o;
   logic          flush_i, empty_o;

   bp_be_mmu_tracker #(
      .els_p(ELS), .eaddr_width_p(AW), .data_width_p(DW),
      .fu_op_width_p(OW), .exc_width_p(EW), .itag_width_p(TW)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i),
      .cmd_data_i(cmd_data_i), .cmd_itag_i(cmd_itag_i),
      .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
      .mem_cmd_op_o(mem_cmd_op_o), .mem_cmd_addr_o(mem_cmd_addr_o),
      .mem_cmd_data_o(mem_cmd_data_o),
      .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i),
      .mem_resp_exc_i(mem_resp_exc_i),
      .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
      .resp_data_o(resp_data_o), .resp_exc_o(resp_exc_o),
      .resp_itag_o(resp_itag_o),
      .flush_i(flush_i), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [TW-1:0] itag;
      logic [OW-1:0] op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [EW-1:0] exc;
      bit            killed;
   } ent_t;

   // Model: waiting-to-issue, waiting-for-response, done-not-retired.
   ent_t q_a[$];
   ent_t q_i[$];
   ent_t q_d[$];
   logic [TW-1:0] got[$];
   int n_cmp = 0;
   int n_err = 0;

   function automatic int occ();
      return q_a.size() + q_i.size() + q_d.size();
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q_a.delete();
      q_i.delete();
      q_d.delete();
   endtask

   // One clock: drive inputs, check outputs, advance model at the edge.
   task automatic cyc(input bit cv, input logic [TW-1:0] it,
                      input bit mr, input bit rv, input bit rr,
                      input bit fl, output bit acc);
      ent_t e;
      bit ecr, emv, erv;
      e.itag = it;
      e.op = OW'($urandom);
      e.addr = {$urandom, $urandom};
      e.data = {$urandom, $urandom};
      e.exc = '0;
      e.killed = 1'b0;
      cmd_v_i = cv;
      cmd_itag_i = it;
      cmd_op_i = e.op;
      cmd_addr_i = e.addr;
      cmd_data_i = e.data;
      mem_cmd_ready_i = mr;
      mem_resp_v_i = rv;
      mem_resp_data_i = {$urandom, $urandom};
      mem_resp_exc_i = EW'($urandom);
      resp_ready_i = rr;
      flush_i = fl;
      #1;
      ecr = (occ() < ELS) && !fl;
      emv = (q_a.size() > 0) && !fl;
      erv = (q_d.size() > 0) && !q_d[0].killed && !fl;
      chk("cmd_ready", 64'(cmd_ready_o), 64'(ecr));
      chk("mem_cmd_v", 64'(mem_cmd_v_o), 64'(emv));
      chk("resp_v", 64'(resp_v_o), 64'(erv));
      chk("empty", 64'(empty_o), 64'(occ() == 0));
      if (emv) begin
         chk("mem_addr", mem_cmd_addr_o, q_a[0].addr);
         chk("mem_data", mem_cmd_data_o, q_a[0].data);
         chk("mem_op", 64'(mem_cmd_op_o), 64'(q_a[0].op));
      end
      if (erv) begin
         chk("resp_itag", 64'(resp_itag_o), 64'(q_d[0].itag));
         chk("resp_data", resp_data_o, q_d[0].data);
         chk("resp_exc", 64'(resp_exc_o), 64'(q_d[0].exc));
      end
      if (resp_v_o && rr)
         got.push_back(resp_itag_o);
      @(posedge clk_i);
      if (q_d.size() > 0 && (q_d[0].killed || (erv && rr)))
         void'(q_d.pop_front());
      if (rv && q_i.size() > 0) begin
         ent_t c;
         c = q_i.pop_front();
         c.data = mem_resp_data_i;
         c.exc = mem_resp_exc_i;
         c.killed = c.killed | fl;
         q_d.push_back(c);
      end
      if (emv && mr)
         q_i.push_back(q_a.pop_front());
      if (fl) begin
         foreach (q_i[k]) q_i[k].killed = 1'b1;
         foreach (q_d[k]) q_d[k].killed = 1'b1;
         q_a.delete();
      end
      acc = cv && ecr;
      if (acc)
         q_a.push_back(e);
      #1;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int k = 0; k < n; k++) cyc(0, '0, 0, 0, 1, 0, a);
   endtask

   task automatic drain();
      bit a;
      for (int k = 0; k < 60 && occ() > 0; k++)
         cyc(0, '0, 1, q_i.size() > 0, 1, 0, a);
      chk("drain_bound", 64'(occ()), 64'd0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
      chk({tag, "_mem_cmd_v"}, 64'(mem_cmd_v_o), 64'd0);
      chk({tag, "_resp_v"}, 64'(resp_v_o), 64'd0);
      chk({tag, "_empty"}, 64'(empty_o), 64'd1);
   endtask

   initial begin
      bit a;
      int t;
      logic [TW-1:0] nxt;
      reset_n_i = 1'b0;
      cmd_v_i = 0; cmd_op_i = '0; cmd_addr_i = '0;
      cmd_data_i = '0; cmd_itag_i = '0;
      mem_cmd_ready_i = 0; mem_resp_v_i = 0;
      mem_resp_data_i = '0; mem_resp_exc_i = '0;
      resp_ready_i = 0; flush_i = 0;
      #3;
      reset_checks("rst");
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Single load with the canonical itag/address/data.
      got.delete();
      cmd_v_i = 1; cmd_itag_i = 32'h7;
      cmd_addr_i = 64'h8000_0124; cmd_data_i = '0; cmd_op_i = '0;
      mem_cmd_ready_i = 1; resp_ready_i = 1;
      mem_resp_v_i = 0; flush_i = 0;
      #1;
      chk("ld_cmd_ready", 64'(cmd_ready_o), 64'd1);
      begin
         ent_t e;
         e.itag = 32'h7; e.op = '0; e.addr = 64'h8000_0124;
         e.data = '0; e.exc = '0; e.killed = 0;
         @(posedge clk_i);
         q_a.push_back(e);
         #1;
      end
      cmd_v_i = 0;
      #1;
      chk("ld_mem_v", 64'(mem_cmd_v_o), 64'd1);
      chk("ld_mem_addr", mem_cmd_addr_o, 64'h8000_0124);
      @(posedge clk_i);
      q_i.push_back(q_a.pop_front());
      #1;
      mem_resp_v_i = 1; mem_resp_data_i = 64'hDEAD_BEEF;
      mem_resp_exc_i = '0; mem_cmd_ready_i = 0;
      #1;
      chk("ld_resp_v_early", 64'(resp_v_o), 64'd0);
      @(posedge clk_i);
      begin
         ent_t c;
         c = q_i.pop_front();
         c.data = 64'hDEAD_BEEF; c.exc = '0;
         q_d.push_back(c);
      end
      #1;
      mem_resp_v_i = 0;
      #1;
      chk("ld_resp_v", 64'(resp_v_o), 64'd1);
      chk("ld_resp_data", resp_data_o, 64'hDEAD_BEEF);
      chk("ld_resp_itag", 64'(resp_itag_o), 64'h7);
      @(posedge clk_i);
      void'(q_d.pop_front());
      #1;
      idle(1);
      chk("ld_empty_after", 64'(empty_o), 64'd1);

      // Fill with memory stalled: fifth command must be refused.
      for (int k = 0; k < 5; k++) begin
         cyc(1, TW'(16 + k), 0, 0, 1, 0, a);
         chk("fill_accept", 64'(a), 64'(k < ELS));
      end
      chk("fill_not_empty", 64'(empty_o), 64'd0);
      drain();

      // Back-pressure: three done responses held behind resp_ready=0.
      got.delete();
      for (int k = 0; k < 3; k++) cyc(1, TW'(32 + k), 1, 0, 1, 0, a);
      cyc(0, '0, 1, 0, 0, 0, a);
      for (int k = 0; k < 3; k++) cyc(0, '0, 1, 1, 0, 0, a);
      for (int k = 0; k < 5; k++) cyc(0, '0, 0, 0, 0, 0, a);
      drain();
      chk("bp_count", 64'(got.size()), 64'd3);
      for (int k = 0; k < 3 && k < got.size(); k++)
         chk("bp_order", 64'(got[k]), 64'(32 + k));

      // Flush with two issued and two unissued entries.
      got.delete();
      cyc(1, 32'd40, 1, 0, 1, 0, a);
      cyc(1, 32'd41, 1, 0, 1, 0, a);
      cyc(1, 32'd42, 1, 0, 1, 0, a);
      cyc(1, 32'd43, 0, 0, 1, 0, a);
      chk("fl_inflight", 64'(q_i.size()), 64'd2);
      cyc(0, '0, 0, 0, 1, 1, a);
      cyc(0, '0, 0, 1, 1, 0, a);
      cyc(0, '0, 0, 1, 1, 0, a);
      idle(2);
      chk("fl_no_resp", 64'(got.size()), 64'd0);
      chk("fl_empty", 64'(empty_o), 64'd1);

      // Wrap: ten commands through the ring with random handshakes.
      got.delete();
      nxt = '0;
      for (int k = 0; k < 400 && nxt < 10; k++) begin
         cyc(1, nxt, 1'($urandom), 1'($urandom), 1'($urandom), 0, a);
         if (a) nxt++;
      end
      chk("wrap_all_sent", 64'(nxt), 64'd10);
      drain();
      chk("wrap_count", 64'(got.size()), 64'd10);
      for (int k = 0; k < 10 && k < got.size(); k++)
         chk("wrap_order", 64'(got[k]), 64'(k));

      // Random traffic with occasional flushes.
      nxt = 32'd100;
      for (int k = 0; k < 400; k++) begin
         cyc(1'($urandom), nxt, 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 19) == 0), a);
         if (a) nxt++;
      end
      drain();

      // Asynchronous reset between clock edges, mid-stream.
      for (int k = 0; k < 3; k++) cyc(1, TW'(200 + k), 1, 0, 0, 0, a);
      cyc(0, '0, 0, 1, 0, 0, a);
      cmd_v_i = 0; mem_resp_v_i = 0; flush_i = 0;
      mem_cmd_ready_i = 0; resp_ready_i = 0;
      #2;
      reset_n_i = 1'b0;
      #1;
      reset_checks("arst");
      model_clear();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      cyc(0, '0, 1, 1, 1, 0, a);
      cyc(0, '0, 1, 1, 1, 0, a);
      t = 0;
      idle(1);
      chk("arst_empty", 64'(empty_o), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
